// File: rtl/shift_display_driver.sv
// shift_display_driver
//   Serial driver for chains of shift-register display latches (74HC595 style).
//   It keeps one NCHAIN x NBITS frame in a shadow/working double buffer and
//   shifts it out on NCHAIN data lines that share one shift clock. After the
//   shift it pulses the latch strobe. The frame then repeats every FRAME_CYCLES
//   (AUTO_REFRESH=1), or is sent only when a new frame arrives (AUTO_REFRESH=0).
//
// Ports
//   clk          system clock
//   rst_n        asynchronous active-low reset
//   frame_data   new frame, chain c at [c*NBITS +: NBITS]
//   frame_valid  frame_data valid
//   frame_ready  shadow buffer free (transfer on valid & ready)
//   sclk         shift clock to the displays
//   sdata        serial data, one bit per chain
//   sload        latch strobe, active-high
//   sclr_n       display register clear, active-low
//   busy         high while shifting or latching
//   frame_tick   one-cycle pulse on the last latch cycle
//
// state   | meaning
// --------+-------------------------------------------------------------
// S_CLEAR | first cycle after reset, sclr_n held low
// S_IDLE  | on-demand mode, waiting for a pending frame
// S_SHIFT | shifting NBITS bits, low phase then high phase per bit
// S_LATCH | sload high for LOAD_CYCLES
// S_HOLD  | auto mode, padding the frame out to FRAME_CYCLES
module shift_display_driver #(
    parameter int NBITS        = 72,
    parameter int NCHAIN       = 1,
    parameter int SCLK_HALF    = 16,
    parameter int LOAD_CYCLES  = 4096,
    parameter int FRAME_CYCLES = 16384,
    parameter int AUTO_REFRESH = 1,
    parameter int MSB_FIRST    = 0
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NCHAIN*NBITS-1:0] frame_data,
    input  logic                    frame_valid,
    output logic                    frame_ready,
    output logic                    sclk,
    output logic [NCHAIN-1:0]       sdata,
    output logic                    sload,
    output logic                    sclr_n,
    output logic                    busy,
    output logic                    frame_tick
);

    localparam int W       = NCHAIN * NBITS;
    localparam int CNT_MAX = (SCLK_HALF > LOAD_CYCLES) ? SCLK_HALF : LOAD_CYCLES;
    localparam int CW      = $clog2(CNT_MAX + 1);
    localparam int BW      = (NBITS > 1) ? $clog2(NBITS) : 1;
    localparam int FW      = $clog2(FRAME_CYCLES + 1);

    localparam logic [CW-1:0] HALF_LAST  = CW'(SCLK_HALF - 1);
    localparam logic [CW-1:0] LOAD_LAST  = CW'(LOAD_CYCLES - 1);
    localparam logic [BW-1:0] BIT_LAST   = BW'(NBITS - 1);
    localparam logic [FW-1:0] FRAME_LAST = FW'((FRAME_CYCLES > 0) ? FRAME_CYCLES - 1 : 0);

    typedef enum logic [2:0] {S_CLEAR, S_IDLE, S_SHIFT, S_LATCH, S_HOLD} state_t;

    state_t         state, state_nx;
    logic [CW-1:0]  cnt, cnt_nx;
    logic           phase, phase_nx;
    logic [BW-1:0]  bit_idx, bit_nx;
    logic [FW-1:0]  frame_cnt, frame_nx;
    logic           pending, pending_nx;
    logic [W-1:0]   shadow, working, working_nx;
    logic           shift_entry, accept;
    logic [BW-1:0]  sel;
    logic           sclk_nx, sload_nx, busy_nx, tick_nx;
    logic [NCHAIN-1:0] sdata_nx;

    assign accept = frame_valid & frame_ready;

    // State register and all registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_CLEAR;
            cnt         <= '0;
            phase       <= 1'b0;
            bit_idx     <= '0;
            frame_cnt   <= '0;
            pending     <= 1'b0;
            shadow      <= '0;
            working     <= '0;
            frame_ready <= 1'b0;
            sclk        <= 1'b0;
            sdata       <= '0;
            sload       <= 1'b0;
            sclr_n      <= 1'b0;
            busy        <= 1'b0;
            frame_tick  <= 1'b0;
        end else begin
            state       <= state_nx;
            cnt         <= cnt_nx;
            phase       <= phase_nx;
            bit_idx     <= bit_nx;
            frame_cnt   <= frame_nx;
            pending     <= pending_nx;
            working     <= working_nx;
            if (accept) shadow <= frame_data;
            frame_ready <= ~pending_nx;
            sclk        <= sclk_nx;
            sdata       <= sdata_nx;
            sload       <= sload_nx;
            sclr_n      <= 1'b1;
            busy        <= busy_nx;
            frame_tick  <= tick_nx;
        end
    end

    // Next-state and counter logic
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        phase_nx = phase;
        bit_nx   = bit_idx;
        // Saturates so short frames cannot wrap the counter back below the compare
        frame_nx = (frame_cnt == FRAME_LAST) ? frame_cnt : frame_cnt + 1'b1;
        case (state)
            S_CLEAR: state_nx = (AUTO_REFRESH != 0) ? S_SHIFT : S_IDLE;
            S_IDLE:  if (pending) state_nx = S_SHIFT;
            S_SHIFT: begin
                if (cnt != '0) begin
                    cnt_nx = cnt - 1'b1;
                end else if (!phase) begin
                    phase_nx = 1'b1;
                    cnt_nx   = HALF_LAST;
                end else if (bit_idx != BIT_LAST) begin
                    phase_nx = 1'b0;
                    cnt_nx   = HALF_LAST;
                    bit_nx   = bit_idx + 1'b1;
                end else begin
                    state_nx = S_LATCH;
                    cnt_nx   = LOAD_LAST;
                end
            end
            S_LATCH: begin
                if (cnt != '0)                 cnt_nx   = cnt - 1'b1;
                else if (AUTO_REFRESH == 0)    state_nx = S_IDLE;
                else if (frame_cnt == FRAME_LAST) state_nx = S_SHIFT;
                else                           state_nx = S_HOLD;
            end
            S_HOLD:  if (frame_cnt == FRAME_LAST) state_nx = S_SHIFT;
            default: state_nx = S_CLEAR;
        endcase

        shift_entry = (state_nx == S_SHIFT) && (state != S_SHIFT);
        if (shift_entry) begin
            cnt_nx   = HALF_LAST;
            phase_nx = 1'b0;
            bit_nx   = '0;
            frame_nx = '0;
        end

        // A capture in the entry cycle lands in shadow after working has taken
        // the old shadow, so it stays pending for the following frame.
        pending_nx = accept | (pending & ~shift_entry);
        working_nx = shift_entry ? shadow : working;
    end

    // Output decode from next-state values, registered above
    always_comb begin
        sel      = (MSB_FIRST != 0) ? BIT_LAST - bit_nx : bit_nx;
        sdata_nx = '0;
        if (state_nx == S_SHIFT) begin
            for (int c = 0; c < NCHAIN; c++) begin
                sdata_nx[c] = working_nx[c*NBITS + int'(sel)];
            end
        end
        sclk_nx  = (state_nx == S_SHIFT) && phase_nx;
        sload_nx = (state_nx == S_LATCH);
        busy_nx  = (state_nx == S_SHIFT) || (state_nx == S_LATCH);
        tick_nx  = (state_nx == S_LATCH) && (cnt_nx == '0);
    end

endmodule

// File: doc/shift_display_driver.md
# shift_display_driver

Parametrised serial driver for chains of shift-register display drivers (e.g. 74HC595-style segment/LED latches). It holds one frame of NCHAIN×NBITS pixel bits in a double buffer and shifts it out on NCHAIN parallel data lines with a common shift clock. It then pulses the latch strobe and repeats at a fixed frame rate, or only on new data. It sits between the display-content logic and the board's display connector, and supersedes the fixed 72-bit single-chain driver.

## Interface
- NBITS, 72: bits per chain; ≥1.
- NCHAIN, 1: independent serial data lines sharing sclk/sload/sclr_n; ≥1.
- SCLK_HALF, 16: clk cycles per sclk half-period; ≥1.
- LOAD_CYCLES, 4096: sload high duration in clk cycles; ≥1.
- FRAME_CYCLES, 16384: clk cycles from SHIFT entry to next SHIFT entry (auto mode).
- AUTO_REFRESH, 1: 1 = re-shift the current frame every FRAME_CYCLES; 0 = shift only when a new frame is accepted.
- MSB_FIRST, 0: 0 = bit 0 of each chain shifted first; 1 = bit NBITS-1 first.
- clk  in  1  system clock.
- rst_n  in  1  reset, asynchronous, active-low.
- frame_data  in  NCHAIN*NBITS  new frame; chain c uses frame_data[c*NBITS +: NBITS].
- frame_valid  in  1  frame_data valid.
- frame_ready  out  1  shadow buffer free; transfer on frame_valid & frame_ready.
- sclk  out  1  shift clock to the displays.
- sdata  out  NCHAIN  serial data, one bit per chain.
- sload  out  1  latch strobe, active-high.
- sclr_n  out  1  display register clear, active-low.
- busy  out  1  high in SHIFT or LATCH.
- frame_tick  out  1  one-cycle pulse at the end of each LATCH.

## Operation
- Buffers: shadow (written by handshake) and working (shifted). Both are cleared to 0 by reset.
- Flag pending: set on an accepted transfer; cleared on SHIFT entry, when working <= shadow. frame_ready = ~pending, registered.
- State CLEAR: entered on reset. sclr_n is held 0 for exactly one clk after rst_n deasserts, then sclr_n = 1 permanently. Exits to SHIFT if AUTO_REFRESH, else to IDLE.
- State IDLE (AUTO_REFRESH=0 only): sclk = 0, sdata = 0. Moves to SHIFT on the cycle after pending is set.
- State SHIFT: sends NBITS bits. Each bit has a low phase (SCLK_HALF cycles, sdata updated at the start) followed by a high phase (SCLK_HALF cycles, sdata stable). Every chain presents the same bit index simultaneously. Total duration is 2*SCLK_HALF*NBITS cycles. Exits to LATCH.
- State LATCH: sclk = 0, sdata = 0, sload = 1 for LOAD_CYCLES cycles. frame_tick pulses on the last LATCH cycle. Exits to HOLD if AUTO_REFRESH, else to IDLE.
- State HOLD: outputs idle, waiting until the frame counter reaches FRAME_CYCLES-1, then SHIFT.
  - The frame counter is zeroed on SHIFT entry and is wide enough for FRAME_CYCLES.
  - If FRAME_CYCLES ≤ 2*SCLK_HALF*NBITS + LOAD_CYCLES, HOLD lasts 0 cycles: LATCH goes directly to SHIFT.
- Auto mode with no new data: the working buffer is reloaded from the unchanged shadow, so the same frame repeats.
- Capture and SHIFT entry in the same cycle: only possible when pending = 0. SHIFT takes the old shadow, the new data sets pending, and the new frame appears in the next frame.
- frame_data may change freely once accepted; the shifted data never changes mid-frame.

## Timing
- Reset values (asynchronous):
  - sclr_n = 0, sload = 0, sclk = 0, sdata = 0.
  - frame_ready = 0, busy = 0, frame_tick = 0.
  - State CLEAR, all counters 0.
- All outputs are registered; none is combinational from inputs.
- frame_ready rises 1 clk after rst_n deasserts.
- frame_ready falls the clk after an accept and rises the clk after SHIFT entry.
- Latency, AUTO_REFRESH=0: accept at edge N → pending at N → SHIFT entry at N+1 → first sclk rise at N+1+SCLK_HALF.
- Reset during any state: immediate return to reset values; the in-flight frame and shadow are discarded.

## Test plan
All scenarios use NBITS=8, NCHAIN=2, SCLK_HALF=2, LOAD_CYCLES=3, FRAME_CYCLES=64, MSB_FIRST=0 unless stated.
- Reset/startup:
  - Stimulus: release rst_n, AUTO_REFRESH=1.
  - Response: sclr_n low 1 clk then high; 8 sclk pulses with sdata = 00.
  - Response: sload high 3 clk; frame_tick once; next SHIFT starts 64 clk after the first.
- Data and order:
  - Stimulus: accept frame_data = 16'hA53C.
  - Response: on the next frame, sdata[0] sampled at sclk rises = 0,0,1,1,1,1,0,0 (0x3C LSB-first) and sdata[1] = 1,0,1,0,0,1,0,1 (0xA5).
  - Stimulus: repeat with MSB_FIRST=1.
  - Response: the reversed sequences.
- Handshake back-pressure:
  - Stimulus: hold frame_valid high with 16'h0001 then 16'h0002 mid-SHIFT.
  - Response: the first is accepted and frame_ready drops.
  - Response: the second is held until the next SHIFT entry and is shown one frame later.
  - Response: the current frame's sdata is unaffected.
- On-demand mode:
  - Stimulus: AUTO_REFRESH=0, no valid.
  - Response: IDLE with sclk = 0 indefinitely.
  - Stimulus: one accept of 16'hFFFF.
  - Response: exactly one SHIFT+LATCH, with SHIFT entry 1 clk after the accept, then back to IDLE.
- Short frame:
  - Stimulus: FRAME_CYCLES=10 (< 32+3).
  - Response: LATCH is followed immediately by SHIFT, giving a period of 35 clk with no HOLD cycles.
- Mid-frame reset:
  - Stimulus: assert rst_n low during bit 4 of SHIFT.
  - Response: all outputs return to reset values in the same cycle.
  - Response: after release, a cleared (all-zero) frame is shifted.
